// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART command-frame path: CRC constants, FSM states,
// the 3.5-character silence constant and the CRC-16/MODBUS byte step.
package uart_frame_tx_pkg;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam int          BYTE3_5    = 30380;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  // Reflected polynomial, LSB of the data byte processed first, no final xor.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Request and byte-level UART transmit handshake between the frame initiator
// (slave side) and its environment: request source and UART tx (master side).
interface uart_frame_tx_if #(
  parameter int MAX_PAY = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [7:0]             req_cmd;
  logic [2:0]             req_len;
  logic [8*MAX_PAY-1:0]   req_payload;
  logic [7:0]             tx_data;
  logic                   tx_int;
  logic                   tx_end;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output req_valid, req_cmd, req_len, req_payload, tx_end,
    input  req_ready, tx_data, tx_int, busy, frame_done
  );

  modport slave (
    input  req_valid, req_cmd, req_len, req_payload, tx_end,
    output req_ready, tx_data, tx_int, busy, frame_done
  );
endinterface

// File: rtl/uart_frame_tx_crc.sv
// One-byte CRC-16/MODBUS update, purely combinational; also usable by the rx CRC path.
module crc16_byte_step
  import uart_frame_tx_pkg::*;
(
  input  logic [15:0] crc_in_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_out_o
);

  assign crc_out_o = crc16_step(crc_in_i, data_i);

endmodule

// File: rtl/uart_frame_tx.sv
// Command-frame initiator: takes one request, streams cmd + payload + CRC16 (high byte
// first) into the byte UART transmitter and enforces the inter-frame silence.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int MAX_PAY    = 5,
  parameter int GAP_CYCLES = BYTE3_5,
  parameter int BUSY_TO    = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_tx_if.slave bus
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int               TO_W     = $clog2(BUSY_TO + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TO - 1);
  localparam logic [2:0]       MAX_LEN  = 3'(MAX_PAY);

  state_e               state_q;
  logic [GAP_W-1:0]     gap_q;
  logic [TO_W-1:0]      to_q;
  logic [3:0]           idx_q;
  logic [3:0]           total_q;
  logic [2:0]           len_q;
  logic [7:0]           cmd_q;
  logic [8*MAX_PAY-1:0] pay_q;
  logic [15:0]          crc_q;
  logic [7:0]           tx_data_q;
  logic                 tx_int_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ready_q;

  logic [2:0]  len_clamp;
  logic [3:0]  pay_sel;
  logic [7:0]  pay_byte;
  logic [7:0]  byte_d;
  logic        is_data;
  logic [15:0] crc_d;

  assign len_clamp = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;

  // Payload goes out most significant byte first: index 1 selects byte len-1.
  always_comb begin
    pay_sel  = {1'b0, len_q} - idx_q;
    pay_byte = 8'h00;
    for (int k = 0; k < MAX_PAY; k++) begin
      if (pay_sel == 4'(k)) pay_byte = pay_q[8*k +: 8];
    end
    is_data = (idx_q <= {1'b0, len_q});
    if (idx_q == 4'd0)                         byte_d = cmd_q;
    else if (is_data)                          byte_d = pay_byte;
    else if (idx_q == {1'b0, len_q} + 4'd1)    byte_d = crc_q[15:8];
    else                                       byte_d = crc_q[7:0];
  end

  crc16_byte_step u_crc (
    .crc_in_i (crc_q),
    .data_i   (byte_d),
    .crc_out_o(crc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_GAP;
      gap_q     <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      total_q   <= '0;
      len_q     <= '0;
      cmd_q     <= '0;
      pay_q     <= '0;
      crc_q     <= CRC16_INIT;
      tx_data_q <= '0;
      tx_int_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      tx_int_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        // Any activity on the line restarts the silence count.
        ST_GAP: begin
          if (bus.tx_end) begin
            gap_q <= '0;
          end else if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            cmd_q   <= bus.req_cmd;
            pay_q   <= bus.req_payload;
            len_q   <= len_clamp;
            total_q <= {1'b0, len_clamp} + 4'd3;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.tx_end) begin
            tx_data_q <= byte_d;
            tx_int_q  <= 1'b1;
            if (is_data) crc_q <= crc_d;
            to_q      <= '0;
            state_q   <= ST_WAIT_BUSY;
          end
        end
        // A UART that never acknowledges must not stall the frame.
        ST_WAIT_BUSY: begin
          if (bus.tx_end || (to_q == TO_LAST)) begin
            state_q <= ST_WAIT_DONE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_end) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q + 4'd1 < total_q) begin
              state_q <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              crc_q   <= CRC16_INIT;
              gap_q   <= '0;
              state_q <= ST_GAP;
            end
          end
        end
        default: state_q <= ST_GAP;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_int     = tx_int_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
